// File: rtl/fir_ctrl.sv
// fir_ctrl: sample-rate controller issuing FIR passes, LMS weight updates, result buffering and weight scan-out.
module fir_ctrl #(
  parameter int TAPS      = 256,
  parameter int MU_SHIFT  = 4,
  parameter int SCAN_BITS = 26,
  parameter int TIMEOUT   = TAPS + 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_a,
  input  logic        adapt_en,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        fir_go,
  output logic [15:0] fir_x_in,
  output logic [15:0] fir_a_in,
  output logic [15:0] fir_weight_adjust,
  input  logic        fir_done,
  input  logic [15:0] fir_out_sample,
  input  logic        scan_req,
  output logic        scan_en,
  output logic        busy,
  output logic        timeout_err,
  output logic        overflow_err,
  input  logic        err_clr
);
  localparam int SCAN_LEN = TAPS * SCAN_BITS;
  localparam int CW = $clog2((SCAN_LEN > TIMEOUT ? SCAN_LEN : TIMEOUT) + 1);
  typedef enum logic [1:0] {IDLE, START, BUSY, SCAN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic live;
  logic signed [15:0] prev_err, shifted;
  logic signed [16:0] neg;
  logic [15:0] wadj;
  logic done_hit, to_hit;
  assign shifted = prev_err >>> MU_SHIFT;
  assign neg = -{shifted[15], shifted};
  // only -(-32768) leaves the 16-bit range, clamp it to +32767
  assign wadj = (neg[16] != neg[15]) ? {neg[16], {15{~neg[16]}}} : neg[15:0];
  assign in_ready = live && state == IDLE && !scan_req;
  assign fir_go = state == START;
  assign scan_en = state == SCAN;
  assign busy = state != IDLE;
  assign done_hit = state == BUSY && fir_done;
  assign to_hit = state == BUSY && !fir_done && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      live <= 1'b0;
      prev_err <= '0;
      fir_x_in <= '0;
      fir_a_in <= '0;
      fir_weight_adjust <= '0;
      res_data <= '0;
      res_valid <= 1'b0;
      timeout_err <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (scan_req) begin
            state <= SCAN;
            cnt <= '0;
          end else if (in_valid && in_ready) begin
            fir_x_in <= in_x;
            fir_a_in <= in_a;
            fir_weight_adjust <= adapt_en ? wadj : 16'h0;
            state <= START;
          end
        end
        START: begin
          state <= BUSY;
          cnt <= '0;
        end
        BUSY: begin
          if (fir_done || to_hit) state <= IDLE;
          else cnt <= cnt + 1'b1;
        end
        SCAN: begin
          if (cnt == CW'(SCAN_LEN - 1)) state <= IDLE;
          else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (done_hit) begin
        res_data <= fir_out_sample;
        prev_err <= fir_out_sample;
      end
      res_valid <= done_hit | (res_valid & ~res_ready);
      overflow_err <= (done_hit & res_valid & ~res_ready) | (overflow_err & ~err_clr);
      timeout_err <= to_hit | (timeout_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: scenario tasks with an arithmetic LMS/result model for fir_ctrl.
module tb_fir_ctrl;
  localparam int TAPS = 256, MU = 4, SCAN_BITS = 26, TIMEOUT = TAPS + 16;
  localparam int SCAN_LEN = TAPS * SCAN_BITS;
  logic clk = 0, rst_n = 0, in_valid = 0, adapt_en = 1, res_ready = 1;
  logic fir_done = 0, scan_req = 0, err_clr = 0;
  logic [15:0] in_x = 0, in_a = 0, fir_out_sample = 0;
  logic in_ready, res_valid, fir_go, scan_en, busy, timeout_err, overflow_err;
  logic [15:0] res_data, fir_x_in, fir_a_in, fir_weight_adjust;
  int checks = 0, failures = 0;
  logic signed [15:0] m_prev = 0;

  fir_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_a(in_a), .adapt_en(adapt_en), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .fir_go(fir_go),
    .fir_x_in(fir_x_in), .fir_a_in(fir_a_in), .fir_weight_adjust(fir_weight_adjust),
    .fir_done(fir_done), .fir_out_sample(fir_out_sample), .scan_req(scan_req),
    .scan_en(scan_en), .busy(busy), .timeout_err(timeout_err),
    .overflow_err(overflow_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] exp_wadj(input logic signed [15:0] p, input logic en);
    int v;
    v = -(int'(p) >>> MU);
    if (v > 32767) v = 32767;
    return en ? 16'(v) : 16'h0;
  endfunction

  task step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] x, input logic [15:0] a);
    int n;
    n = 0;
    in_x = x;
    in_a = a;
    in_valid = 1;
    while (!in_ready && n < 10000) begin
      step;
      n++;
    end
    if (n == 10000) begin
      checks++;
      failures++;
      $display("FAIL accept_wait in_ready=%b required=1", in_ready);
    end
    step;
    in_valid = 0;
  endtask

  // entered during BUSY cycle 1; done is presented in BUSY cycle lat
  task automatic finish_pass(input int lat, input logic [15:0] out);
    repeat (lat - 1) step;
    fir_done = 1;
    fir_out_sample = out;
    step;
    fir_done = 0;
    m_prev = out;
  endtask

  task test_reset;
    step;
    step;
    checks++;
    if ({in_ready, res_valid, fir_go, scan_en, busy, timeout_err, overflow_err, res_data, fir_x_in, fir_a_in, fir_weight_adjust} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {in_ready, res_valid, fir_go, scan_en, busy, timeout_err, overflow_err, res_data, fir_x_in, fir_a_in, fir_weight_adjust});
    end
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_release_ready got=%b required=0", in_ready); end
    step;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b required=1", in_ready); end
    m_prev = 0;
  endtask

  task test_single;
    adapt_en = 1;
    res_ready = 1;
    accept(16'h4000, 16'h1000);
    checks++;
    if (fir_go !== 1'b1) begin failures++; $display("FAIL single_go got=%b required=1", fir_go); end
    checks++;
    if (fir_weight_adjust !== 16'h0000) begin failures++; $display("FAIL single_wadj got=%h required=0000", fir_weight_adjust); end
    checks++;
    if ({fir_x_in, fir_a_in} !== {16'h4000, 16'h1000}) begin failures++; $display("FAIL single_xa got=%h required=40001000", {fir_x_in, fir_a_in}); end
    step;
    checks++;
    if ({fir_go, busy, in_ready} !== 3'b010) begin failures++; $display("FAIL single_busy go/busy/ready got=%b required=010", {fir_go, busy, in_ready}); end
    finish_pass(270, 16'h1234);
    checks++;
    if ({res_valid, res_data, busy} !== {1'b1, 16'h1234, 1'b0}) begin failures++; $display("FAIL single_result got=%h required=%h", {res_valid, res_data, busy}, {1'b1, 16'h1234, 1'b0}); end
    step;
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b required=0", res_valid); end
  endtask

  task test_lms;
    accept(16'h0001, 16'h0002);
    checks++;
    if (fir_weight_adjust !== 16'hFEDD) begin failures++; $display("FAIL lms_1234 got=%h required=FEDD", fir_weight_adjust); end
    step;
    finish_pass(20, 16'h8000);
    accept(16'h0003, 16'h0004);
    checks++;
    if (fir_weight_adjust !== 16'h0800) begin failures++; $display("FAIL lms_8000 got=%h required=0800", fir_weight_adjust); end
    step;
    finish_pass(10, 16'h0321);
    adapt_en = 0;
    accept(16'h0005, 16'h0006);
    checks++;
    if (fir_weight_adjust !== 16'h0000) begin failures++; $display("FAIL lms_frozen got=%h required=0000", fir_weight_adjust); end
    step;
    finish_pass(7, 16'hFFF0);
    adapt_en = 1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] x, a, out;
    logic en;
    int lat;
    for (int i = 0; i < 20; i++) begin
      x = 16'($urandom);
      a = 16'($urandom);
      out = 16'($urandom);
      en = 1'($urandom);
      lat = (i == 0) ? TIMEOUT : $urandom_range(1, TIMEOUT);
      adapt_en = en;
      accept(x, a);
      checks++;
      if ({fir_x_in, fir_a_in, fir_weight_adjust} !== {x, a, exp_wadj(m_prev, en)}) begin
        failures++;
        $display("FAIL b2b_launch[%0d] got=%h required=%h", i, {fir_x_in, fir_a_in, fir_weight_adjust}, {x, a, exp_wadj(m_prev, en)});
      end
      step;
      finish_pass(lat, out);
      checks++;
      if ({res_valid, res_data, timeout_err} !== {1'b1, out, 1'b0}) begin
        failures++;
        $display("FAIL b2b_result[%0d] lat=%0d got=%h required=%h", i, lat, {res_valid, res_data, timeout_err}, {1'b1, out, 1'b0});
      end
    end
    adapt_en = 1;
    step;
  endtask

  task automatic test_backpressure;
    logic [15:0] r1, r2, r3;
    r1 = 16'($urandom);
    r2 = 16'($urandom);
    r3 = 16'($urandom);
    res_ready = 0;
    accept(16'h1111, 16'h2222);
    step;
    finish_pass(5, r1);
    checks++;
    if ({res_valid, overflow_err, res_data} !== {2'b10, r1}) begin failures++; $display("FAIL bp_first got=%h required=%h", {res_valid, overflow_err, res_data}, {2'b10, r1}); end
    accept(16'h3333, 16'h4444);
    step;
    finish_pass(8, r2);
    checks++;
    if ({res_valid, overflow_err, res_data} !== {2'b11, r2}) begin failures++; $display("FAIL bp_overwrite got=%h required=%h", {res_valid, overflow_err, res_data}, {2'b11, r2}); end
    err_clr = 1;
    step;
    err_clr = 0;
    checks++;
    if ({res_valid, overflow_err} !== 2'b10) begin failures++; $display("FAIL bp_clear got=%b required=10", {res_valid, overflow_err}); end
    accept(16'h5555, 16'h6666);
    step;
    repeat (3) step;
    fir_done = 1;
    fir_out_sample = r3;
    res_ready = 1;
    step;
    fir_done = 0;
    res_ready = 0;
    m_prev = r3;
    checks++;
    if ({res_valid, overflow_err, res_data} !== {2'b10, r3}) begin failures++; $display("FAIL bp_drain_and_load got=%h required=%h", {res_valid, overflow_err, res_data}, {2'b10, r3}); end
    res_ready = 1;
    step;
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_final_drain got=%b required=0", res_valid); end
  endtask

  task automatic test_timeout;
    int n;
    res_ready = 1;
    accept(16'h7000, 16'h0700);
    step;
    n = 0;
    while (busy && n < TIMEOUT + 50) begin
      step;
      n++;
    end
    checks++;
    if (n !== TIMEOUT) begin failures++; $display("FAIL timeout_cycles got=%0d required=%0d", n, TIMEOUT); end
    checks++;
    if ({timeout_err, res_valid} !== 2'b10) begin failures++; $display("FAIL timeout_flag err/valid got=%b required=10", {timeout_err, res_valid}); end
    fir_done = 1;
    fir_out_sample = 16'h7777;
    step;
    fir_done = 0;
    checks++;
    if ({res_valid, busy} !== 2'b00) begin failures++; $display("FAIL stray_done valid/busy got=%b required=00", {res_valid, busy}); end
    accept(16'h0101, 16'h0202);
    checks++;
    if (fir_weight_adjust !== exp_wadj(m_prev, 1'b1)) begin failures++; $display("FAIL timeout_prev_kept got=%h required=%h", fir_weight_adjust, exp_wadj(m_prev, 1'b1)); end
    step;
    finish_pass(4, 16'($urandom));
  endtask

  task test_reset_mid_busy;
    res_ready = 0;
    accept(16'h0A0A, 16'h0B0B);
    step;
    finish_pass(6, 16'h4321);
    accept(16'h0C0C, 16'h0D0D);
    step;
    step;
    checks++;
    if ({busy, res_valid, timeout_err} !== 3'b111) begin failures++; $display("FAIL midreset_pre busy/valid/terr got=%b required=111", {busy, res_valid, timeout_err}); end
    rst_n = 0;
    #2;
    checks++;
    if ({fir_go, scan_en, res_valid, busy, timeout_err, overflow_err, in_ready} !== 7'b0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b required=0000000", {fir_go, scan_en, res_valid, busy, timeout_err, overflow_err, in_ready});
    end
    m_prev = 0;
    res_ready = 1;
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_release_ready got=%b required=0", in_ready); end
    step;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready_rise got=%b required=1", in_ready); end
    accept(16'h0E0E, 16'h0F0F);
    checks++;
    if (fir_weight_adjust !== exp_wadj(m_prev, 1'b1)) begin failures++; $display("FAIL midreset_prev_cleared got=%h required=%h", fir_weight_adjust, exp_wadj(m_prev, 1'b1)); end
    step;
    finish_pass(3, 16'h0040);
  endtask

  task automatic test_scan;
    int n;
    logic bad;
    n = 0;
    bad = 0;
    scan_req = 1;
    in_x = 16'h2468;
    in_a = 16'h1357;
    in_valid = 1;
    step;
    scan_req = 0;
    while (scan_en && n < SCAN_LEN + 100) begin
      if (fir_go || in_ready || !busy) bad = 1;
      n++;
      step;
    end
    checks++;
    if (n !== SCAN_LEN) begin failures++; $display("FAIL scan_len got=%0d required=%0d", n, SCAN_LEN); end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL scan_quiet got=%b required=0", bad); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL scan_exit_ready got=%b required=1", in_ready); end
    step;
    in_valid = 0;
    checks++;
    if ({fir_go, fir_x_in, fir_a_in} !== {1'b1, 16'h2468, 16'h1357}) begin failures++; $display("FAIL scan_then_accept got=%h required=%h", {fir_go, fir_x_in, fir_a_in}, {1'b1, 16'h2468, 16'h1357}); end
    step;
    finish_pass(3, 16'h0001);
  endtask

  initial begin
    test_reset;
    test_single;
    test_lms;
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_reset_mid_busy;
    test_scan;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
